kaipokrandt_port1_inconditioner: RTL and testbench

//  Conditions the raw external input pins feeding port1 and produces its ext_in word and load_ext strobe.
//  Raw pins pass through a 2-flop synchronizer and a word-level stability filter.
//  A new value is delivered, with a one-cycle load_ext pulse, only after it has been stable for STABLE_CYCLES cycles.

---
 rtl/kaipokrandt_port1_inconditioner.sv | 103 ++++++++++
 tb/tb_kaipokrandt_port1_inconditioner.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kaipokrandt_port1_inconditioner.sv
// Input conditioner for port1: synchronizes the raw pins, filters the word for stability
// and hands each newly settled value to port1 together with a one-cycle load strobe.
module kaipokrandt_port1_inconditioner #(
  parameter int WIDTH         = 16,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pin_in,
  input  logic             enable,
  input  logic             force_load,
  input  logic             clr_glitch,
  output logic [WIDTH-1:0] ext_in,
  output logic             load_ext,
  output logic             glitch
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    DELIVER = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);

  logic [WIDTH-1:0] s1_r;
  logic [WIDTH-1:0] s2_r;
  logic [WIDTH-1:0] cand_r;
  logic [CNT_W-1:0] cnt_r;
  state_t           state_r;
  logic             diff_s;
  logic             stable_s;

  // Candidate change detect and stability test on the synchronized word
  always_comb begin
    diff_s   = (s2_r != cand_r);
    stable_s = (cnt_r == STABLE_CNT);
  end

  // Two-flop synchronizer and saturating run-length counter for the candidate
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_r   <= '0;
      s2_r   <= '0;
      cand_r <= '0;
      cnt_r  <= '0;
    end else begin
      s1_r <= pin_in;
      s2_r <= s1_r;
      if (diff_s) begin
        cand_r <= s2_r;
        cnt_r  <= CNT_W'(1);
      end else if (cnt_r < STABLE_CNT) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Delivery FSM with registered ext_in, load_ext and sticky glitch flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      ext_in   <= '0;
      load_ext <= 1'b0;
      glitch   <= 1'b0;
    end else begin
      // A bounce seen while settling outranks a simultaneous clear
      if (state_r == SETTLE && diff_s) begin
        glitch <= 1'b1;
      end else if (clr_glitch) begin
        glitch <= 1'b0;
      end

      load_ext <= 1'b0;
      if (force_load) begin
        ext_in   <= s2_r;
        state_r  <= DELIVER;
        load_ext <= 1'b1;
      end else begin
        case (state_r)
          IDLE: begin
            if (cand_r != ext_in) begin
              state_r <= SETTLE;
            end
          end
          SETTLE: begin
            if (cand_r == ext_in) begin
              state_r <= IDLE;
            end else if (stable_s && enable) begin
              state_r  <= DELIVER;
              ext_in   <= cand_r;
              load_ext <= 1'b1;
            end
          end
          DELIVER: state_r <= IDLE;
          default: state_r <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kaipokrandt_port1_inconditioner.sv
// Self-checking bench for kaipokrandt_port1_inconditioner: directed scenarios plus a
// randomized run compared against a delay-line / run-length reference model.
module tb_kaipokrandt_port1_inconditioner;

  localparam int WIDTH  = 16;
  localparam int STABLE = 4;

  logic             clk        = 1'b0;
  logic             reset      = 1'b0;
  logic [WIDTH-1:0] pin_in     = 16'h0000;
  logic             enable     = 1'b1;
  logic             force_load = 1'b0;
  logic             clr_glitch = 1'b0;
  logic [WIDTH-1:0] ext_in;
  logic             load_ext;
  logic             glitch;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Reference model: sync_q is the two-stage pipe, m_run the length of the current run
  logic [WIDTH-1:0] sync_q[$];
  logic [WIDTH-1:0] m_cand;
  logic [WIDTH-1:0] m_ext;
  int               m_run;
  bit               m_pend;
  bit               m_strobe;
  bit               m_glitch;

  kaipokrandt_port1_inconditioner #(
    .WIDTH(WIDTH), .STABLE_CYCLES(STABLE), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .pin_in(pin_in), .enable(enable),
    .force_load(force_load), .clr_glitch(clr_glitch),
    .ext_in(ext_in), .load_ext(load_ext), .glitch(glitch)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    sync_q.delete();
    sync_q.push_back(16'h0000);
    sync_q.push_back(16'h0000);
    m_cand   = 16'h0000;
    m_ext    = 16'h0000;
    m_run    = 0;
    m_pend   = 1'b0;
    m_strobe = 1'b0;
    m_glitch = 1'b0;
  endfunction

  function automatic void model_edge();
    logic [WIDTH-1:0] synced;
    bit pend_n;
    bit strobe_n;
    synced = sync_q.pop_front();
    sync_q.push_back(pin_in);
    if (m_pend && synced != m_cand) m_glitch = 1'b1;
    else if (clr_glitch) m_glitch = 1'b0;
    pend_n   = m_pend;
    strobe_n = 1'b0;
    if (force_load) begin
      m_ext = synced; strobe_n = 1'b1; pend_n = 1'b0;
    end else if (m_strobe) begin
      pend_n = 1'b0;
    end else if (!m_pend) begin
      pend_n = (m_cand != m_ext);
    end else if (m_cand == m_ext) begin
      pend_n = 1'b0;
    end else if (m_run >= STABLE && enable) begin
      m_ext = m_cand; strobe_n = 1'b1; pend_n = 1'b0;
    end
    m_pend   = pend_n;
    m_strobe = strobe_n;
    if (synced != m_cand) begin
      m_cand = synced; m_run = 1;
    end else if (m_run < STABLE) begin
      m_run = m_run + 1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    int bad;
    model_reset();
    #1;
    n_total++;
    if (ext_in !== 16'h0000 || load_ext !== 1'b0 || glitch !== 1'b0)
      $display("FAIL reset_values: ext_in=%h load_ext=%b glitch=%b, required 0000 0 0", ext_in, load_ext, glitch);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (load_ext !== 1'b0 || ext_in !== 16'h0000 || glitch !== 1'b0) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL idle_zero: %0d bad cycles, required 0", bad);
    else n_pass++;
  endtask

  task automatic test_latency();
    int n;
    pin_in = 16'hA5A5;
    n = 0;
    while (n < 20) begin
      tick();
      n++;
      if (load_ext === 1'b1) break;
    end
    n_total++;
    if (n != 7 || ext_in !== 16'hA5A5)
      $display("FAIL latency: load after edge %0d ext_in=%h, required edge 7 A5A5", n, ext_in);
    else n_pass++;
    tick();
    n_total++;
    if (load_ext !== 1'b0 || ext_in !== 16'hA5A5)
      $display("FAIL single_pulse: load_ext=%b ext_in=%h, required 0 A5A5", load_ext, ext_in);
    else n_pass++;
  endtask

  task automatic test_glitch();
    int pulses;
    int wrong;
    int bad;
    pulses = 0; wrong = 0; bad = 0;
    for (int i = 0; i < 27; i++) begin
      if (i < 12) pin_in = ((i / 2) % 2 == 1) ? 16'hA5A5 : 16'h0000;
      else pin_in = 16'h1234;
      tick();
      if (load_ext !== m_strobe || ext_in !== m_ext || glitch !== m_glitch) bad++;
      if (load_ext === 1'b1) begin
        pulses++;
        if (ext_in !== 16'h1234) wrong++;
      end
    end
    n_total++;
    if (bad != 0) $display("FAIL glitch_model: %0d cycles differ from model, required 0", bad);
    else n_pass++;
    n_total++;
    if (pulses != 1 || wrong != 0 || ext_in !== 16'h1234)
      $display("FAIL bounce_delivery: pulses=%0d wrong=%0d ext_in=%h, required 1 0 1234", pulses, wrong, ext_in);
    else n_pass++;
    n_total++;
    if (glitch !== 1'b1) $display("FAIL glitch_set: glitch=%b, required 1", glitch);
    else n_pass++;
    clr_glitch = 1'b1;
    tick();
    clr_glitch = 1'b0;
    n_total++;
    if (glitch !== 1'b0) $display("FAIL glitch_clear: glitch=%b, required 0", glitch);
    else n_pass++;
  endtask

  task automatic test_enable();
    int pulses;
    enable = 1'b0;
    pin_in = 16'h00FF;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (load_ext === 1'b1) pulses++;
    end
    n_total++;
    if (pulses != 0 || ext_in !== 16'h1234)
      $display("FAIL enable_hold: pulses=%0d ext_in=%h, required 0 1234", pulses, ext_in);
    else n_pass++;
    enable = 1'b1;
    tick();
    n_total++;
    if (load_ext !== 1'b1 || ext_in !== 16'h00FF)
      $display("FAIL enable_release: load_ext=%b ext_in=%h, required 1 00FF", load_ext, ext_in);
    else n_pass++;
    tick();
  endtask

  task automatic test_force();
    int pulses;
    pin_in = 16'hBEEF;
    tick();
    tick();
    force_load = 1'b1;
    tick();
    force_load = 1'b0;
    n_total++;
    if (load_ext !== 1'b1 || ext_in !== 16'hBEEF)
      $display("FAIL force_load: load_ext=%b ext_in=%h, required 1 BEEF", load_ext, ext_in);
    else n_pass++;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (load_ext === 1'b1) pulses++;
    end
    n_total++;
    if (pulses != 0 || ext_in !== 16'hBEEF)
      $display("FAIL force_no_repeat: pulses=%0d ext_in=%h, required 0 BEEF", pulses, ext_in);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [2:0] seen;
    pin_in = 16'h1357;
    tick();
    tick();
    force_load = 1'b1;
    tick();
    seen[2] = load_ext;
    tick();
    seen[1] = load_ext;
    force_load = 1'b0;
    tick();
    seen[0] = load_ext;
    n_total++;
    if (seen !== 3'b110 || ext_in !== 16'h1357)
      $display("FAIL back_to_back: load pattern=%b ext_in=%h, required 110 1357", seen, ext_in);
    else n_pass++;
  endtask

  task automatic test_random();
    int bad;
    int hold;
    bad = 0;
    hold = 0;
    for (int i = 0; i < 400; i++) begin
      if (hold == 0) begin
        pin_in = 16'h1111 * 16'($urandom_range(0, 3));
        hold = $urandom_range(1, 8);
      end
      hold--;
      enable     = ($urandom_range(0, 9) != 0);
      force_load = ($urandom_range(0, 29) == 0);
      clr_glitch = ($urandom_range(0, 14) == 0);
      tick();
      if (load_ext !== m_strobe || ext_in !== m_ext || glitch !== m_glitch) begin
        bad++;
        if (bad <= 5)
          $display("FAIL random cycle %0d: ext_in=%h load_ext=%b glitch=%b, required %h %b %b",
                   i, ext_in, load_ext, glitch, m_ext, m_strobe, m_glitch);
      end
    end
    force_load = 1'b0;
    clr_glitch = 1'b0;
    enable     = 1'b1;
    n_total++;
    if (bad != 0) $display("FAIL random_total: %0d mismatching cycles, required 0", bad);
    else n_pass++;
  endtask

  task automatic test_reset_mid_settle();
    int n;
    pin_in = 16'h4444;
    for (int i = 0; i < 5; i++) tick();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    n_total++;
    if (ext_in !== 16'h0000 || load_ext !== 1'b0 || glitch !== 1'b0)
      $display("FAIL async_reset: ext_in=%h load_ext=%b glitch=%b, required 0000 0 0", ext_in, load_ext, glitch);
    else n_pass++;
    pin_in = 16'h0F0F;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    while (n < 20) begin
      tick();
      n++;
      if (load_ext === 1'b1) break;
    end
    n_total++;
    if (n != 7 || ext_in !== 16'h0F0F)
      $display("FAIL reset_relatency: load after edge %0d ext_in=%h, required edge 7 0F0F", n, ext_in);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_enable();
    test_force();
    test_back_to_back();
    test_random();
    test_reset_mid_settle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
